// File: rtl/memory_read_streamer.sv
// Command-driven read streamer: walks simple_memory from a base address with a
// fixed stride and presents each multi-element read as a registered valid/ready beat.
module memory_read_streamer #(
    parameter int DATA_WIDTH                   = 8,
    parameter int PARALLEL_DATA_STREAMING_SIZE = 4,
    parameter int SIZE                         = 1024,
    parameter int ADDRESS_BITS                 = $clog2(SIZE + 1),
    parameter int LENGTH_BITS                  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDRESS_BITS-1:0] cmd_base_address,
    input  logic [LENGTH_BITS-1:0]  cmd_num_beats,
    input  logic [ADDRESS_BITS-1:0] cmd_stride,

    output logic [ADDRESS_BITS-1:0] mem_read_address,
    input  logic [DATA_WIDTH-1:0]   mem_read_data [PARALLEL_DATA_STREAMING_SIZE],

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data [PARALLEL_DATA_STREAMING_SIZE],
    output logic                    out_last,

    output logic                    range_error,
    output logic                    done,
    output logic [1:0]              dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both high. The source keeps valid (and its payload) stable until then;
    // ready may change freely and never depends combinationally on valid here.

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    localparam logic [ADDRESS_BITS:0]  LP_BEAT_ELEMS = (ADDRESS_BITS + 1)'(PARALLEL_DATA_STREAMING_SIZE);
    localparam logic [ADDRESS_BITS:0]  LP_SIZE       = (ADDRESS_BITS + 1)'(SIZE);
    localparam logic [LENGTH_BITS-1:0] LP_ONE_BEAT   = LENGTH_BITS'(1);

    state_t                  r_state;
    state_t                  w_state_next;

    logic [ADDRESS_BITS-1:0] r_addr;
    logic [ADDRESS_BITS-1:0] r_stride;
    logic [LENGTH_BITS-1:0]  r_remaining;
    logic [DATA_WIDTH-1:0]   r_out_data [PARALLEL_DATA_STREAMING_SIZE];
    logic                    r_out_valid;
    logic                    r_out_last;
    logic                    r_range_error;
    logic                    r_done;

    logic                    w_cmd_ready;
    logic                    w_accept;
    logic                    w_load;
    logic                    w_flush_hs;
    logic [ADDRESS_BITS:0]   w_window_end;
    logic                    w_range_hit;

    // One extra bit so a window running past the top of the address space
    // is still seen as out of range rather than wrapping to a small value.
    assign w_window_end = {1'b0, r_addr} + LP_BEAT_ELEMS;
    assign w_range_hit  = (w_window_end > LP_SIZE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cmd_ready  = 1'b0;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_flush_hs   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    if (cmd_num_beats != '0) begin
                        w_state_next = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                // Refill whenever the output register is empty or being drained.
                w_load = (!r_out_valid || out_ready) && (r_remaining != '0);
                if (w_load && (r_remaining == LP_ONE_BEAT)) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (out_ready) begin
                    w_flush_hs   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr        <= '0;
            r_stride      <= '0;
            r_remaining   <= '0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_range_error <= 1'b0;
            r_done        <= 1'b0;
            for (int i = 0; i < PARALLEL_DATA_STREAMING_SIZE; i++) begin
                r_out_data[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;

            if (w_accept) begin
                r_addr        <= cmd_base_address;
                r_remaining   <= cmd_num_beats;
                r_stride      <= cmd_stride;
                r_range_error <= 1'b0;
                if (cmd_num_beats == '0) begin
                    r_done <= 1'b1;
                end
            end

            if (w_load) begin
                r_out_data  <= mem_read_data;
                r_out_valid <= 1'b1;
                r_out_last  <= (r_remaining == LP_ONE_BEAT);
                r_addr      <= r_addr + r_stride;
                r_remaining <= r_remaining - LP_ONE_BEAT;
                if (w_range_hit) begin
                    r_range_error <= 1'b1;
                end
            end else if ((r_state == ST_STREAM) && r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end

            if (w_flush_hs) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_done      <= 1'b1;
            end
        end
    end

    assign cmd_ready        = w_cmd_ready;
    assign mem_read_address = r_addr;
    assign out_valid        = r_out_valid;
    assign out_data         = r_out_data;
    assign out_last         = r_out_last;
    assign range_error      = r_range_error;
    assign done             = r_done;
    assign dbg_state        = r_state;

endmodule

// File: tb/tb_memory_read_streamer.sv
// Directed bench for memory_read_streamer with a behavioural combinational memory
// preloaded with 1..16 at addresses 0..15 and zero elsewhere.
module tb_memory_read_streamer;

    localparam int DW = 8;
    localparam int P  = 4;
    localparam int SZ = 1024;
    localparam int AB = $clog2(SZ + 1);
    localparam int LB = 16;

    logic          clk;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AB-1:0] cmd_base_address;
    logic [LB-1:0] cmd_num_beats;
    logic [AB-1:0] cmd_stride;
    logic [AB-1:0] mem_read_address;
    logic [DW-1:0] mem_read_data [P];
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data [P];
    logic          out_last;
    logic          range_error;
    logic          done;
    logic [1:0]    dbg_state;

    logic [DW-1:0] mem [SZ];
    logic [31:0]   exp_q[$];
    int            n_asserts;
    int            n_fail;
    int            n_cycles;

    memory_read_streamer #(
        .DATA_WIDTH(DW), .PARALLEL_DATA_STREAMING_SIZE(P), .SIZE(SZ),
        .ADDRESS_BITS(AB), .LENGTH_BITS(LB)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base_address(cmd_base_address), .cmd_num_beats(cmd_num_beats),
        .cmd_stride(cmd_stride),
        .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .range_error(range_error), .done(done),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // combinational memory model; addresses past the end read as zero
    always_comb begin
        for (int i = 0; i < P; i++) begin
            if (int'(mem_read_address) + i < SZ) mem_read_data[i] = mem[int'(mem_read_address) + i];
            else                                 mem_read_data[i] = '0;
        end
    end

    function automatic logic [31:0] pack_out();
        return {out_data[0], out_data[1], out_data[2], out_data[3]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver: present a command at a negedge, leave at the negedge after acceptance
    task automatic issue_cmd(input string tag, input int base, input int beats, input int stride);
        cmd_valid        = 1'b1;
        cmd_base_address = AB'(base);
        cmd_num_beats    = LB'(beats);
        cmd_stride       = AB'(stride);
        #1;
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // scoreboard drain: consumes exp_q under a ready pattern, then checks done
    task automatic drain(input string tag, input logic [15:0] pat, output int cycles);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            out_ready = pat[cyc % 16];
            #1;
            if (out_valid) begin
                check({tag, "_data"}, pack_out(), exp_q[0]);
                check({tag, "_last"}, {31'd0, out_last}, (exp_q.size() == 1) ? 32'd1 : 32'd0);
                if (out_ready) void'(exp_q.pop_front());
            end
            @(negedge clk);
            cyc++;
        end
        cycles = cyc;
        if (exp_q.size() != 0) begin
            check({tag, "_timeout"}, exp_q.size(), 32'd0);
            exp_q.delete();
        end
        #1;
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        for (int i = 0; i < SZ; i++) mem[i] = (i < 16) ? DW'(i + 1) : '0;
        reset_n          = 1'b0;
        cmd_valid        = 1'b0;
        cmd_base_address = '0;
        cmd_num_beats    = '0;
        cmd_stride       = '0;
        out_ready        = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_last", {31'd0, out_last}, 32'd0);
        check("rst_data", pack_out(), 32'h0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_range", {31'd0, range_error}, 32'd0);
        check("rst_addr", {21'd0, mem_read_address}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // T1: base 0, 4 beats, stride 4, ready held high
        issue_cmd("t1", 0, 4, 4);
        check("t1_lat_valid", {31'd0, out_valid}, 32'd0);
        check("t1_busy", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        check("t1_first_valid", {31'd0, out_valid}, 32'd1);
        exp_q = '{32'h01020304, 32'h05060708, 32'h090a0b0c, 32'h0d0e0f10};
        drain("t1", 16'hffff, n_cycles);
        check("t1_cycles", n_cycles, 32'd4);
        check("t1_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        check("t1_done_pulse", {31'd0, done}, 32'd0);

        // T2: same command, ready pattern 1,0,0,1 repeating
        issue_cmd("t2", 0, 4, 4);
        @(negedge clk);
        exp_q = '{32'h01020304, 32'h05060708, 32'h090a0b0c, 32'h0d0e0f10};
        drain("t2", 16'h9999, n_cycles);
        @(negedge clk);
        check("t2_done_pulse", {31'd0, done}, 32'd0);

        // T3: base 2, 3 beats, stride 1; address walk 2,3,4
        issue_cmd("t3", 2, 3, 1);
        check("t3_addr0", {21'd0, mem_read_address}, 32'd2);
        @(negedge clk);
        check("t3_addr1", {21'd0, mem_read_address}, 32'd3);
        check("t3_beat0", pack_out(), 32'h03040506);
        exp_q = '{32'h03040506, 32'h04050607, 32'h05060708};
        drain("t3", 16'hffff, n_cycles);
        check("t3_addr_end", {21'd0, mem_read_address}, 32'd5);
        @(negedge clk);

        // T4: zero beats
        issue_cmd("t4", 8, 0, 1);
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_state_idle", {30'd0, dbg_state}, 32'd0);
        check("t4_valid", {31'd0, out_valid}, 32'd0);
        check("t4_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        check("t4_done_clear", {31'd0, done}, 32'd0);
        check("t4_valid_later", {31'd0, out_valid}, 32'd0);

        // T5: window past the end of memory
        issue_cmd("t5", SZ - 2, 1, 0);
        @(negedge clk);
        check("t5_range", {31'd0, range_error}, 32'd1);
        exp_q = '{32'h00000000};
        drain("t5", 16'hffff, n_cycles);
        check("t5_range_sticky", {31'd0, range_error}, 32'd1);
        issue_cmd("t5b", 0, 1, 1);
        check("t5b_range_clear", {31'd0, range_error}, 32'd0);
        @(negedge clk);
        exp_q = '{32'h01020304};
        drain("t5b", 16'hffff, n_cycles);
        check("t5b_range_ok", {31'd0, range_error}, 32'd0);
        @(negedge clk);

        // T6: asynchronous reset after beat 2 of 4
        issue_cmd("t6", 0, 4, 4);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("t6_beat2", pack_out(), 32'h05060708);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("t6_rst_last", {31'd0, out_last}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("t6_no_beat", {31'd0, out_valid}, 32'd0);
        check("t6_idle", {30'd0, dbg_state}, 32'd0);
        issue_cmd("t6b", 4, 2, 8);
        check("t6b_addr", {21'd0, mem_read_address}, 32'd4);
        @(negedge clk);
        exp_q = '{32'h05060708, 32'h0d0e0f10};
        drain("t6b", 16'hffff, n_cycles);
        check("t6b_cycles", n_cycles, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_read_streamer.md
Name: memory_read_streamer

Overview:
- Sits between simple_memory and the sum-stationary compute array.
- Takes one command (base address, beat count, stride), drives the memory's combinational read_address, and registers each PARALLEL_DATA_STREAMING_SIZE-wide read into a valid/ready output stream with a last flag.
- Lets the array pull operand rows at its own pace without stalling on memory timing.

Parameters:
- DATA_WIDTH, 8, element width; must match simple_memory.
- PARALLEL_DATA_STREAMING_SIZE, 4, elements per beat; must match simple_memory.
- SIZE, 1024, memory depth in elements.
- ADDRESS_BITS, $clog2(SIZE+1), address width.
- LENGTH_BITS, 16, width of the beat-count field.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  streamer idle and able to accept a command.
- cmd_base_address  in  ADDRESS_BITS  element address of the first beat.
- cmd_num_beats  in  LENGTH_BITS  number of beats to emit; 0 is legal.
- cmd_stride  in  ADDRESS_BITS  element increment between beats.
- mem_read_address  out  ADDRESS_BITS  to simple_memory read_address.
- mem_read_data  in  DATA_WIDTH x PARALLEL_DATA_STREAMING_SIZE (unpacked array)  from simple_memory read_data.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  DATA_WIDTH x PARALLEL_DATA_STREAMING_SIZE  registered beat.
- out_last  out  1  marks the final beat of the command.
- range_error  out  1  sticky flag: a beat's address window exceeded SIZE-1.
- done  out  1  one-cycle pulse when the command completes.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; addr_q=0; remaining=0.
  - out_valid=0, out_last=0, out_data=all 0.
  - range_error=0, done=0.
  - cmd_ready=1 once reset_n deasserts.
  - Reset mid-command abandons the command immediately; no beat is emitted afterwards.
- mem_read_address = addr_q at all times (combinational from the register).
- FSM:
  - IDLE: cmd_ready=1.
    - On cmd_valid: addr_q<=cmd_base_address, remaining<=cmd_num_beats, stride_q<=cmd_stride, range_error<=0.
    - Go to STREAM if cmd_num_beats!=0; otherwise stay in IDLE and pulse done next cycle.
  - STREAM: cmd_ready=0. load = (!out_valid || out_ready) && remaining!=0. On load:
    - out_data<=mem_read_data, out_valid<=1, out_last<=(remaining==1).
    - addr_q<=addr_q+stride_q, remaining<=remaining-1.
    - When the load takes the last beat (remaining==1), go to FLUSH.
  - FLUSH: cmd_ready=0. Hold the final beat until out_ready.
    - On handshake: out_valid<=0, out_last<=0, done<=1 for one cycle, go to IDLE.
- Output register holds out_data/out_last stable while out_valid && !out_ready.
- Steady-state throughput is 1 beat/cycle with out_ready held high. Latency from command acceptance to first out_valid is 2 cycles (IDLE->STREAM, then load).
- If the consumer accepts a beat and a new load is possible in the same cycle, the next beat loads in that cycle with no bubble. out_valid stays 1.
- Arithmetic: addr_q+stride_q is computed in ADDRESS_BITS and wraps modulo 2^ADDRESS_BITS.
- Range check at each load: if addr_q+PARALLEL_DATA_STREAMING_SIZE > SIZE (computed in ADDRESS_BITS+1 bits), set range_error<=1. The beat is still emitted with whatever the memory returns, and range_error stays set until the next command is accepted.
- cmd_valid while cmd_ready=0 is ignored. The upstream source must hold the command until cmd_ready.
- out_valid never drops without a handshake, except on reset.

Test Plan:
- Memory preloaded with 1..16. Command base=0, beats=4, stride=4, out_ready=1 -> beats {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} on 4 consecutive cycles; out_last only on the 4th; done pulses one cycle after the 4th handshake; cmd_ready=1 afterwards.
- Same command with out_ready toggled 1,0,0,1,... -> no beat dropped or duplicated, and out_data is stable while stalled; sequence is identical to the previous test.
- base=2, beats=3, stride=1 -> {3,4,5,6},{4,5,6,7},{5,6,7,8}; mem_read_address steps 2,3,4.
- beats=0 -> out_valid never asserts; done pulses once; cmd_ready returns to 1 with no STREAM cycle.
- base=SIZE-2, beats=1 -> beat emitted with out_last=1 and range_error=1; range_error clears when the next command (base=0) is accepted.
- Assert reset_n=0 mid-stream after beat 2 of 4 -> out_valid=0 and cmd_ready=1 immediately (asynchronously); a new command then streams correctly from its own base address.
